// File: rtl/branch_eta.sv
// DEPTH-stage valid/ready branch pipeline with add/subtract feedback and P/Q output streams.
// Optional saturating stage-1 arithmetic is enabled by defining BRANCH_ETA_SAT_EN.
module branch_eta #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;

  logic             adv;
  logic [WIDTH-1:0] fb;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] arith;

  assign fb  = v_q[DEPTH-1] ? (s_q[DEPTH-1] >> SHIFT) : '0;
  assign adv = (!v_q[DEPTH-1] || out_ready) && !flush;
  assign din = in_valid ? in_data : '0;

`ifdef BRANCH_ETA_SAT_EN
  logic [WIDTH:0] sum_ext;
  logic           borrow;
  assign sum_ext = {1'b0, s_q[0]} + {1'b0, fb};
  assign borrow  = s_q[0] < fb;
  // Clamp on carry-out (add) or borrow (subtract) instead of wrapping.
  assign arith = mode ? (borrow ? '0 : s_q[0] - fb)
                      : (sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0]);
`else
  assign arith = mode ? s_q[0] - fb : s_q[0] + fb;
`endif

  // Global enable: every stage moves together, so bubbles are preserved.
  always_comb begin
    s_d = s_q;
    v_d = v_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) s_d[i] = '0;
      v_d = '0;
    end else if (adv) begin
      s_d[0] = din;
      v_d[0] = in_valid;
      s_d[1] = arith;
      v_d[1] = v_q[0];
      for (int k = 2; k <= DEPTH - 2; k++) begin
        s_d[k] = s_q[k-1];
        v_d[k] = v_q[k-1];
      end
      s_d[DEPTH-1] = s_q[DEPTH-2] ^ din;
      v_d[DEPTH-1] = v_q[DEPTH-2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '{default: '0};
      v_q <= '0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[DEPTH-1];
  assign out_p     = s_q[DEPTH-2] | fb;
  assign out_q     = s_q[0] ^ s_q[DEPTH-1];

endmodule

// File: tb/tb_branch_eta.sv
// Scoreboard bench for branch_eta (WIDTH=16, DEPTH=3, SHIFT=3); honours BRANCH_ETA_SAT_EN
// so the same bench checks either build.
module tb_branch_eta;

  logic        clk = 1'b0;
  logic        rst, flush, mode, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_p, out_q;

  branch_eta #(.WIDTH(16), .DEPTH(3), .SHIFT(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_q(out_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] q;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_hs  = 0;
  logic [15:0] m_s0, m_s1, m_s2;
  logic        m_v0, m_v1, m_v2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] m_fb();
    return m_v2 ? {3'b000, m_s2[15:3]} : 16'h0000;
  endfunction

  function automatic logic [15:0] m_stage1(input logic md, input logic [15:0] a, input logic [15:0] b);
    int r;
    r = md ? int'(a) - int'(b) : int'(a) + int'(b);
`ifdef BRANCH_ETA_SAT_EN
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
`endif
    return r[15:0];
  endfunction

  task automatic m_clear();
    {m_s0, m_s1, m_s2} = '0;
    {m_v0, m_v1, m_v2} = '0;
    sb_q.delete();
  endtask

  // One clock: drive, check against model/scoreboard, clock, update model, push new presentation.
  task automatic cycle(input logic iv, input logic [15:0] id, input logic md,
                       input logic ordy, input logic fl);
    logic        adv;
    logic [15:0] din, n1, fb;
    exp_t        ev;
    in_valid = iv; in_data = id; mode = md; out_ready = ordy; flush = fl;
    #1;
    adv = (!m_v2 || ordy) && !fl;
    chk("in_ready", in_ready, adv);
    chk("out_valid", out_valid, m_v2);
    if (m_v2) begin
      chk("sb_size", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        chk("out_p", out_p, sb_q[0].p);
        chk("out_q", out_q, sb_q[0].q);
        if (adv) begin
          n_hs++;
          $display("beat %0d p=%h q=%h", n_hs, out_p, out_q);
          void'(sb_q.pop_front());
        end
      end
    end else begin
      chk("p_idle", out_p, m_s1);
      chk("q_idle", out_q, m_s0 ^ m_s2);
    end
    @(posedge clk);
    din = iv ? id : 16'h0000;
    fb  = m_fb();
    if (fl) begin
      m_clear();
    end else if (adv) begin
      n1   = m_stage1(md, m_s0, fb);
      m_s2 = m_s1 ^ din; m_v2 = m_v1;
      m_s1 = n1;         m_v1 = m_v0;
      m_s0 = din;        m_v0 = iv;
      if (m_v2) begin
        ev.p = m_s1 | m_fb();
        ev.q = m_s0 ^ m_s2;
        sb_q.push_back(ev);
      end
    end
    @(negedge clk);
  endtask

  // Raises rst between edges and checks outputs clear before any clock edge.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_p", out_p, 0);
    chk("rst_q", out_q, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    m_clear();
    #1 chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic single_beat();
    cycle(1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("sb_valid", out_valid, 1);
    chk("sb_p", out_p, 16'h0002);
    chk("sb_q", out_q, 16'h0010);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("sb_hold", out_valid, 0);
  endtask

  // Primes s[0]=s0val and fb=0x0004 together, then shows stage 1 on out_p (fb is 0 next).
  task automatic sat_case(input string tag, input logic md, input logic [15:0] a,
                          input logic [15:0] s0val, input logic [15:0] want);
    pulse_rst();
    cycle(1'b1, a,        1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, s0val,    1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, md,   1'b1, 1'b0);
    chk(tag, out_p, want);
  endtask

  initial begin
    int          beat;
    int          hs0;
    logic [15:0] r16;
    rst = 1'b0;
    flush = 1'($urandom); mode = 1'($urandom); in_valid = 1'($urandom);
    out_ready = 1'($urandom); in_data = 16'($urandom);
    pulse_rst();

    single_beat();

    // Backpressure: 0x0001..0x0008 with a 4-cycle stall while a beat is presented.
    beat = 1;
    hs0  = n_hs;
    for (int cyc = 0; cyc < 20; cyc++) begin
      logic ordy;
      logic iv;
      ordy = !(cyc >= 3 && cyc < 7);
      iv   = (beat <= 8);
      if (cyc == 3) chk("stall_valid", out_valid, 1);
      cycle(iv, 16'(beat), 1'b0, ordy, 1'b0);
      if (iv && ordy) beat++;
      if (!ordy && sb_q.size() > 0) begin
        chk("stall_p", out_p, sb_q[0].p);
        chk("stall_q", out_q, sb_q[0].q);
      end
    end
    chk("bp_beats", n_hs - hs0, 8);

`ifdef BRANCH_ETA_SAT_EN
    sat_case("sat_sub", 1'b1, 16'h0021, 16'h0001, 16'h0000);
    sat_case("sat_add", 1'b0, 16'hFFDE, 16'hFFFE, 16'hFFFF);
`else
    sat_case("wrap_sub", 1'b1, 16'h0021, 16'h0001, 16'hFFFD);
    sat_case("wrap_add", 1'b0, 16'hFFDE, 16'hFFFE, 16'h0002);
`endif

    // Flush with two beats in flight and a beat offered.
    pulse_rst();
    cycle(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h3333, 1'b0, 1'b1, 1'b1);
    chk("fl_valid", out_valid, 0);
    chk("fl_p", out_p, 0);
    chk("fl_q", out_q, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Async reset during full streaming, then a fresh single beat.
    for (int i = 0; i < 6; i++) begin
      r16 = 16'($urandom);
      cycle(1'b1, r16, 1'($urandom), 1'b1, 1'b0);
    end
    chk("pre_rst_valid", out_valid, 1);
    pulse_rst();
    single_beat();

    // Random traffic with stalls, bubbles, mode changes and occasional flush.
    for (int i = 0; i < 300; i++) begin
      r16 = 16'($urandom);
      cycle($urandom_range(3) != 0, r16, 1'($urandom),
            $urandom_range(3) != 0, $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
